// File: rtl/m_uart_loader.sv
// ---------------------------------------------------------------------------
// m_uart_loader
// Serial program loader. Receives 8N1 UART bytes, assembles little-endian
// 32-bit words and writes them to the instruction/data memory starting at
// word address 0. The processor is held in reset (r_busy=1) until the whole
// image has been written.
//
// Stream format: count[7:0], count[15:8], then count words of 4 bytes each
// (least significant byte first).
//
// Ports
//   w_clk    in   system clock, posedge
//   w_rst_n  in   asynchronous active-low reset
//   w_rxd    in   UART receive line, asynchronous, idle high
//   r_we     out  memory write strobe, one-cycle pulse per word
//   r_addr   out  memory word address for r_we
//   r_wdata  out  memory write data for r_we
//   r_busy   out  1 = processor held in reset (load in progress)
//   r_done   out  1 = load complete, sticky until reset
//   r_err    out  1 = framing or count error, sticky until reset
// ---------------------------------------------------------------------------
module m_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12,
    parameter int MAX_WORDS    = 4096
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_rxd,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [31:0]       r_wdata,
    output logic              r_busy,
    output logic              r_done,
    output logic              r_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);
    localparam logic [16:0] MAX_W     = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [2:0] {
        L_CNT0, L_CNT1, L_DATA, L_WRITE, L_INC, L_DONE
    } ld_state_t;

    logic        r_rxd_meta;
    logic        r_rxd_sync;
    rx_state_t   r_rx_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_byte;
    logic        r_byte_vld;
    logic        r_frame_err;

    ld_state_t   r_ld_state;
    logic [15:0] r_count;
    logic [15:0] r_widx;
    logic [1:0]  r_byte_idx;
    logic [15:0] w_count_new;
    logic [15:0] w_last_idx;

    assign w_count_new = {r_byte, r_count[7:0]};
    assign w_last_idx  = r_count - 16'd1;

    // Two-flop synchronizer for the asynchronous receive line (idle high).
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= w_rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    // UART receive FSM: mid-bit sampling, byte strobe or framing-error pulse.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_state  <= RX_IDLE;
            r_clk_cnt   <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_byte      <= 8'd0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    // Line only reaches IDLE while high, so low here is a falling edge.
                    if (!r_rxd_sync) begin
                        r_rx_state <= RX_START;
                        r_clk_cnt  <= 16'd0;
                        r_bit_cnt  <= 3'd0;
                    end
                end
                RX_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt  <= 16'd0;
                        r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= 16'd0;
                        r_shift   <= {r_rxd_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= 16'd0;
                        if (r_rxd_sync) begin
                            r_byte     <= r_shift;
                            r_byte_vld <= 1'b1;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_rx_state  <= RX_WAIT_HIGH;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // Do not re-arm on a line that is still low after a bad stop bit.
                    if (r_rxd_sync) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Loader FSM: word count header, byte packing, memory writes, status flags.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ld_state <= L_CNT0;
            r_count    <= 16'd0;
            r_widx     <= 16'd0;
            r_byte_idx <= 2'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_frame_err) begin
                r_err <= 1'b1;
            end
            case (r_ld_state)
                L_CNT0: begin
                    if (r_byte_vld) begin
                        r_count[7:0] <= r_byte;
                        r_ld_state   <= L_CNT1;
                    end
                end
                L_CNT1: begin
                    if (r_byte_vld) begin
                        r_count[15:8] <= r_byte;
                        if (w_count_new == 16'd0) begin
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_ld_state <= L_DONE;
                        end else if ({1'b0, w_count_new} > MAX_W) begin
                            r_err      <= 1'b1;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_ld_state <= L_DONE;
                        end else begin
                            r_byte_idx <= 2'd0;
                            r_widx     <= 16'd0;
                            r_addr     <= '0;
                            r_ld_state <= L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (r_byte_vld) begin
                        case (r_byte_idx)
                            2'd0:    r_wdata[7:0]   <= r_byte;
                            2'd1:    r_wdata[15:8]  <= r_byte;
                            2'd2:    r_wdata[23:16] <= r_byte;
                            2'd3:    r_wdata[31:24] <= r_byte;
                            default: r_wdata[7:0]   <= r_byte;
                        endcase
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_we       <= 1'b1;
                            r_ld_state <= L_WRITE;
                        end
                    end
                end
                L_WRITE: begin
                    // r_we drops here; address advances one cycle later.
                    if (r_widx == w_last_idx) begin
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_ld_state <= L_DONE;
                    end else begin
                        r_ld_state <= L_INC;
                    end
                end
                L_INC: begin
                    r_addr     <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    r_widx     <= r_widx + 16'd1;
                    r_ld_state <= L_DATA;
                end
                L_DONE: begin
                    r_ld_state <= L_DONE;
                end
                default: begin
                    r_ld_state <= L_CNT0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_m_uart_loader
// Directed stimulus with a write scoreboard: expected (addr, data) pairs are
// queued when a stream is issued; a monitor pops and compares on each r_we.
// ---------------------------------------------------------------------------
module tb_m_uart_loader;

    logic        clk;
    logic        rst_n;
    logic        rxd;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];

    m_uart_loader #(
        .CLKS_PER_BIT(4),
        .ADDR_W(12),
        .MAX_WORDS(4096)
    ) dut (
        .w_clk  (clk),
        .w_rst_n(rst_n),
        .w_rxd  (rxd),
        .r_we   (we),
        .r_addr (addr),
        .r_wdata(wdata),
        .r_busy (busy),
        .r_done (done),
        .r_err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write monitor: every r_we must match the head of the expectation queue.
    always @(negedge clk) begin : mon
        wr_t e;
        if (rst_n === 1'b1 && we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%h data=%h required=none", addr, wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {20'd0, addr}, {20'd0, e.a});
                chk("write_data", wdata, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (4) @(negedge clk);
        end
        rxd = stop;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic status(input string name, input logic d, input logic b, input logic e);
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({name, "_err"},  {31'd0, err},  {31'd0, e});
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        chk({name, "_rst_we"},    {31'd0, we},    32'd0);
        chk({name, "_rst_addr"},  {20'd0, addr},  32'd0);
        chk({name, "_rst_wdata"}, wdata,          32'd0);
        status({name, "_rst"}, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_empty(input string name);
        chk({name, "_pending_writes"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b1;

        // Scenario 1: two-word image.
        do_reset("s1");
        exp_q.push_back('{a: 12'h000, d: 32'h00000020});
        exp_q.push_back('{a: 12'h001, d: 32'h20081000});
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        status("s1_mid", 1'b0, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        send_byte(8'h08, 1'b1); send_byte(8'h20, 1'b1);
        status("s1_end", 1'b1, 1'b0, 1'b0);
        chk("s1_final_addr", {20'd0, addr}, 32'd1);
        send_byte(8'h55, 1'b1); // ignored once done
        expect_empty("s1");

        // Scenario 2: empty image.
        do_reset("s2");
        send_byte(8'h00, 1'b1);
        status("s2_mid", 1'b0, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1);
        status("s2_end", 1'b1, 1'b0, 1'b0);
        expect_empty("s2");

        // Scenario 3: framing error then resend.
        do_reset("s3");
        send_byte(8'h02, 1'b0);
        status("s3_ferr", 1'b0, 1'b1, 1'b1);
        exp_q.push_back('{a: 12'h000, d: 32'h00000020});
        exp_q.push_back('{a: 12'h001, d: 32'h20081000});
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        send_byte(8'h08, 1'b1); send_byte(8'h20, 1'b1);
        status("s3_end", 1'b1, 1'b0, 1'b1);
        expect_empty("s3");

        // Scenario 4: count 0x1001 exceeds the limit.
        do_reset("s4");
        send_byte(8'h01, 1'b1); send_byte(8'h10, 1'b1);
        status("s4_end", 1'b1, 1'b0, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        expect_empty("s4");

        // Scenario 5: reset in the middle of word 1, then a fresh image.
        do_reset("s5");
        exp_q.push_back('{a: 12'h000, d: 32'h00000020});
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        expect_empty("s5_pre");
        do_reset("s5_mid");
        exp_q.push_back('{a: 12'h000, d: 32'hDDCCBBAA});
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
        status("s5_end", 1'b1, 1'b0, 1'b0);
        expect_empty("s5");

        // Scenario 6: one-clock glitch while idle, then a normal one-word image.
        do_reset("s6");
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        status("s6_glitch", 1'b0, 1'b1, 1'b0);
        exp_q.push_back('{a: 12'h000, d: 32'h04030201});
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        status("s6_end", 1'b1, 1'b0, 1'b0);
        expect_empty("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
